// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo setpoint range and repeat FSM state type
// Purpose : setpoint limits/defaults common to the setpoint controller and the
//           PWM stage, plus the per-button repeat FSM state encoding.
// Ports   : none (package).
package servo_pkg;

    localparam int SERVO_SP_W      = 11;
    localparam int SERVO_SP_MIN    = 25;
    localparam int SERVO_SP_MAX    = 125;
    localparam int SERVO_SP_INIT   = 25;
    localparam int SERVO_STEP_SIZE = 5;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - sync, debounce and hold-to-repeat for one active-low button
// Purpose : turns a raw asynchronous active-low button into one-cycle step pulses:
//           a step on each debounced press, then auto-repeat while held.
// Ports   : clk     - system clock
//           rst     - asynchronous active-low reset
//           en      - while low, no steps and the repeat FSM is held in idle
//           btn_raw - raw button, active-low, asynchronous to clk
//           step    - one-cycle step request
module btn_conditioner
    import servo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_raw,
    output logic step
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_RATE - 1);

    logic             sync1, sync2;
    logic [1:0]       vld;
    logic             db_level, db_d;
    logic [DB_W-1:0]  db_cnt;
    logic             press_q;
    logic             armed;
    rpt_state_t       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;

    // The debounced level resets to "released", so a button already held at
    // reset would otherwise debounce into a fake press. Presses only count once
    // the button has been seen genuinely released after reset (vld marks the
    // synchroniser holding real samples rather than its reset value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            vld      <= 2'b00;
            db_level <= 1'b1;
            db_d     <= 1'b1;
            db_cnt   <= '0;
            press_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            if (sync2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            db_d    <= db_level;
            press_q <= db_d & ~db_level;
            if (vld[1] && sync2 && db_level) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step      = 1'b0;
        if (!en || db_level) begin
            state_nxt = RPT_IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (press_q && armed) begin
                        step      = 1'b1;
                        state_nxt = RPT_DELAY;
                        timer_nxt = '0;
                    end
                end
                RPT_DELAY: begin
                    if (timer == DLY_LAST) begin
                        step      = 1'b1;
                        state_nxt = RPT_REPEAT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (timer == RPT_LAST) begin
                        step      = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RPT_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

endmodule

// File: rtl/servo_setpoint_ctrl.sv
// rtl/servo_setpoint_ctrl.sv - saturating servo duty setpoint driven by inc/dec buttons
// Purpose : conditions two raw buttons and keeps a clamped duty setpoint for the PWM stage.
// Ports   : clk        - system clock
//           rst        - asynchronous active-low reset
//           en         - step enable; setpoint holds while low
//           btn_inc    - raw increment button, active-low
//           btn_dec    - raw decrement button, active-low
//           setpoint   - registered duty setpoint
//           sp_changed - one-cycle pulse when setpoint took a new value
//           at_min     - setpoint == SP_MIN (registered)
//           at_max     - setpoint == SP_MAX (registered)
module servo_setpoint_ctrl
    import servo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000,
    parameter int SP_W            = SERVO_SP_W,
    parameter int SP_MIN          = SERVO_SP_MIN,
    parameter int SP_MAX          = SERVO_SP_MAX,
    parameter int SP_INIT         = SERVO_SP_INIT,
    parameter int STEP_SIZE       = SERVO_STEP_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            btn_inc,
    input  logic            btn_dec,
    output logic [SP_W-1:0] setpoint,
    output logic            sp_changed,
    output logic            at_min,
    output logic            at_max
);

    typedef logic [SP_W:0] wide_t;

    localparam wide_t MIN_X  = wide_t'(SP_MIN);
    localparam wide_t MAX_X  = wide_t'(SP_MAX);
    localparam wide_t STEP_X = wide_t'(STEP_SIZE);

    logic            step_inc, step_dec;
    wide_t           sp_x, inc_x;
    logic [SP_W-1:0] sp_next;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_cond_inc (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .btn_raw (btn_inc),
        .step    (step_inc)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_cond_dec (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .btn_raw (btn_dec),
        .step    (step_dec)
    );

    // One extra bit keeps the sum from wrapping; the decrement is guarded by
    // the wide compare so the narrow subtraction only runs when it cannot go
    // below SP_MIN.
    always_comb begin
        sp_x    = {1'b0, setpoint};
        inc_x   = sp_x + STEP_X;
        sp_next = setpoint;
        case ({step_inc, step_dec})
            2'b10: sp_next = (inc_x > MAX_X) ? SP_W'(SP_MAX) : inc_x[SP_W-1:0];
            2'b01: sp_next = (sp_x < MIN_X + STEP_X) ? SP_W'(SP_MIN)
                                                     : setpoint - SP_W'(STEP_SIZE);
            default: sp_next = setpoint;  // none, or both cancelling
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setpoint   <= SP_W'(SP_INIT);
            sp_changed <= 1'b0;
            at_min     <= (SP_INIT == SP_MIN);
            at_max     <= (SP_INIT == SP_MAX);
        end else begin
            setpoint   <= sp_next;
            sp_changed <= (sp_next != setpoint);
            at_min     <= (sp_next == SP_W'(SP_MIN));
            at_max     <= (sp_next == SP_W'(SP_MAX));
        end
    end

endmodule

// File: tb/tb_servo_setpoint_ctrl.sv
// tb/tb_servo_setpoint_ctrl.sv - scoreboard bench for servo_setpoint_ctrl
module tb_servo_setpoint_ctrl;

    localparam int SP_W = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            btn_inc;
    logic            btn_dec;
    logic [SP_W-1:0] setpoint;
    logic            sp_changed;
    logic            at_min;
    logic            at_max;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int sb[$];
    int stamps[$];
    int exp_sp;
    int lat;
    int found;

    servo_setpoint_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .setpoint   (setpoint),
        .sp_changed (sp_changed),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every sp_changed pulse must match the next expected setpoint.
    always @(negedge clk) begin
        if (rst && sp_changed) begin
            if (sb.size() == 0) begin
                chk("unexpected_change", int'(setpoint), -1);
            end else begin
                exp_sp = sb.pop_front();
                chk("sb_setpoint", int'(setpoint), exp_sp);
                chk("sb_at_max", int'(at_max), int'(exp_sp == 125));
                chk("sb_at_min", int'(at_min), int'(exp_sp == 25));
                stamps.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; btn_inc = 1'b1; btn_dec = 1'b1;
        tick(3);
        chk("rst_setpoint", int'(setpoint), 25);
        chk("rst_at_min", int'(at_min), 1);
        chk("rst_at_max", int'(at_max), 0);
        chk("rst_changed", int'(sp_changed), 0);
        rst = 1'b1;
        tick(10);
        chk("idle_setpoint", int'(setpoint), 25);

        // single press: latency from raw edge to sp_changed
        sb.push_back(30);
        btn_inc = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            if (k == 10) begin
                #1 btn_inc = 1'b1;
            end
            @(negedge clk);
            if (sp_changed && lat < 0) lat = k;
        end
        chk("press_latency", lat, 8);
        tick(10);
        chk("single_press", int'(setpoint), 30);
        btn_dec = 1'b0;
        tick(3);
        btn_dec = 1'b1;
        tick(20);
        chk("glitch_ignored", int'(setpoint), 30);

        // repeat up to 60, then async reset with button still held
        for (int v = 35; v <= 60; v += 5) sb.push_back(v);
        btn_inc = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (setpoint == 60) found = 1;
        end
        chk("reach_60", found, 1);
        tick(3);
        chk("sb_drained_60", sb.size(), 0);
        sb.delete();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sp", int'(setpoint), 25);
        chk("async_rst_min", int'(at_min), 1);
        tick(2);
        rst = 1'b1;
        tick(40);
        chk("held_after_rst", int'(setpoint), 25);
        btn_inc = 1'b1;
        tick(15);
        sb.push_back(30);
        btn_inc = 1'b0;
        tick(10);
        btn_inc = 1'b1;
        tick(20);
        chk("repress_after_rst", int'(setpoint), 30);

        // long hold: repeat cadence and clamp at SP_MAX
        stamps.delete();
        for (int v = 35; v <= 125; v += 5) sb.push_back(v);
        btn_inc = 1'b0;
        tick(200);
        btn_inc = 1'b1;
        tick(20);
        chk("clamp_max", int'(setpoint), 125);
        chk("clamp_at_max", int'(at_max), 1);
        chk("hold_steps", stamps.size(), 19);
        if (stamps.size() >= 3) begin
            chk("repeat_delay", stamps[1] - stamps[0], 20);
            chk("repeat_rate", stamps[2] - stamps[1], 8);
        end else begin
            chk("repeat_stamps", stamps.size(), 3);
        end

        // simultaneous presses cancel, then a lone decrement
        btn_inc = 1'b0; btn_dec = 1'b0;
        tick(12);
        btn_inc = 1'b1; btn_dec = 1'b1;
        tick(20);
        chk("both_cancel", int'(setpoint), 125);
        sb.push_back(120);
        btn_dec = 1'b0;
        tick(10);
        btn_dec = 1'b1;
        tick(20);
        chk("dec_alone", int'(setpoint), 120);

        // press while disabled, enable with button still held
        en = 1'b0;
        btn_dec = 1'b0;
        tick(30);
        en = 1'b1;
        tick(40);
        btn_dec = 1'b1;
        tick(20);
        chk("en_held_no_step", int'(setpoint), 120);
        sb.push_back(115);
        btn_dec = 1'b0;
        tick(10);
        btn_dec = 1'b1;
        tick(20);
        chk("dec_after_en", int'(setpoint), 115);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
